// File: rtl/mem_bus_pkg.sv
// Shared definitions for the L1-to-SDRAM arbitration path: state encoding, grant IDs and
// default bus widths.
package mem_bus_pkg;

  localparam int unsigned DefAddrWidth = 32;
  localparam int unsigned DefDataWidth = 32;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] BUSY_I    = 3'd1;
  localparam logic [2:0] BUSY_D    = 3'd2;
  localparam logic [2:0] RELEASE_I = 3'd3;
  localparam logic [2:0] RELEASE_D = 3'd4;

  typedef enum logic [2:0] {
    StIdle     = IDLE,
    StBusyI    = BUSY_I,
    StBusyD    = BUSY_D,
    StReleaseI = RELEASE_I,
    StReleaseD = RELEASE_D
  } state_e;

  localparam logic GrantI = 1'b0;
  localparam logic GrantD = 1'b1;

endpackage

// File: rtl/l1_sdram_arbiter_if.sv
// Bundles both L1 client buses and the SDRAM controller bus seen by the arbiter.
interface l1_sdram_arbiter_if
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DATA_WIDTH = DefDataWidth
) ();

  logic [ADDR_WIDTH-1:0] i_addr;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_we;
  logic                  i_start;
  logic [DATA_WIDTH-1:0] i_q;
  logic                  i_done;

  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_data;
  logic                  d_we;
  logic                  d_start;
  logic [DATA_WIDTH-1:0] d_q;
  logic                  d_done;

  logic [ADDR_WIDTH-1:0] sdc_addr;
  logic [DATA_WIDTH-1:0] sdc_data;
  logic                  sdc_we;
  logic                  sdc_start;
  logic [DATA_WIDTH-1:0] sdc_q;
  logic                  sdc_done;

  // Arbiter side
  modport slave (
    input  i_addr, i_data, i_we, i_start, d_addr, d_data, d_we, d_start, sdc_q, sdc_done,
    output i_q, i_done, d_q, d_done, sdc_addr, sdc_data, sdc_we, sdc_start
  );

  // Clients plus controller side
  modport master (
    output i_addr, i_data, i_we, i_start, d_addr, d_data, d_we, d_start, sdc_q, sdc_done,
    input  i_q, i_done, d_q, d_done, sdc_addr, sdc_data, sdc_we, sdc_start
  );

endinterface

// File: rtl/l1_sdram_arbiter.sv
// Merges the L1 I-miss and D-miss buses onto one SDRAM controller bus, one whole
// transaction at a time, with round-robin or D-priority tie breaking.
module l1_sdram_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter bit          RR_ENABLE  = 1'b1
) (
  input logic               clk,
  input logic               reset,
  l1_sdram_arbiter_if.slave bus
);

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] sdc_addr_q, sdc_addr_d;
  logic [DATA_WIDTH-1:0] sdc_data_q, sdc_data_d;
  logic                  sdc_we_q, sdc_we_d;
  logic                  sdc_start_q, sdc_start_d;
  logic [DATA_WIDTH-1:0] i_q_q, i_q_d;
  logic                  i_done_q, i_done_d;
  logic [DATA_WIDTH-1:0] d_q_q, d_q_d;
  logic                  d_done_q, d_done_d;
  logic                  grant;

  function automatic logic pick_grant(logic i_req, logic d_req, logic last);
    if (i_req && d_req) begin
      return RR_ENABLE ? ~last : GrantD;
    end
    return d_req ? GrantD : GrantI;
  endfunction

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    sdc_addr_d   = sdc_addr_q;
    sdc_data_d   = sdc_data_q;
    sdc_we_d     = sdc_we_q;
    sdc_start_d  = sdc_start_q;
    i_q_d        = i_q_q;
    d_q_d        = d_q_q;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;
    grant        = GrantI;

    unique case (state_q)
      StIdle: begin
        if (bus.i_start || bus.d_start) begin
          grant        = pick_grant(bus.i_start, bus.d_start, last_grant_q);
          last_grant_d = grant;
          sdc_start_d  = 1'b1;
          if (grant == GrantD) begin
            sdc_addr_d = bus.d_addr;
            sdc_data_d = bus.d_data;
            sdc_we_d   = bus.d_we;
            state_d    = StBusyD;
          end else begin
            sdc_addr_d = bus.i_addr;
            sdc_data_d = bus.i_data;
            sdc_we_d   = bus.i_we;
            state_d    = StBusyI;
          end
        end
      end
      StBusyI: begin
        if (bus.sdc_done) begin
          sdc_start_d = 1'b0;
          i_q_d       = bus.sdc_q;
          i_done_d    = 1'b1;
          state_d     = StReleaseI;
        end
      end
      StBusyD: begin
        if (bus.sdc_done) begin
          sdc_start_d = 1'b0;
          d_q_d       = bus.sdc_q;
          d_done_d    = 1'b1;
          state_d     = StReleaseD;
        end
      end
      // Wait out the client's registered start deassert so it is not re-granted.
      StReleaseI: if (!bus.i_start) state_d = StIdle;
      StReleaseD: if (!bus.d_start) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      last_grant_q <= GrantD;
      sdc_addr_q   <= '0;
      sdc_data_q   <= '0;
      sdc_we_q     <= 1'b0;
      sdc_start_q  <= 1'b0;
      i_q_q        <= '0;
      i_done_q     <= 1'b0;
      d_q_q        <= '0;
      d_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      sdc_addr_q   <= sdc_addr_d;
      sdc_data_q   <= sdc_data_d;
      sdc_we_q     <= sdc_we_d;
      sdc_start_q  <= sdc_start_d;
      i_q_q        <= i_q_d;
      i_done_q     <= i_done_d;
      d_q_q        <= d_q_d;
      d_done_q     <= d_done_d;
    end
  end

  assign bus.sdc_addr  = sdc_addr_q;
  assign bus.sdc_data  = sdc_data_q;
  assign bus.sdc_we    = sdc_we_q;
  assign bus.sdc_start = sdc_start_q;
  assign bus.i_q       = i_q_q;
  assign bus.i_done    = i_done_q;
  assign bus.d_q       = d_q_q;
  assign bus.d_done    = d_done_q;

endmodule

// File: tb/tb_l1_sdram_arbiter.sv
// Directed bench for l1_sdram_arbiter: a round-robin and a fixed-priority instance share
// stimulus; per-client expectation queues plus a tiny arbitration model predict each grant.
module tb_l1_sdram_arbiter;

  typedef struct {
    logic        port;
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
  } txn_t;

  logic clk;
  logic reset;
  bit   sel;  // 0: round-robin DUT observed, 1: fixed-priority DUT observed

  logic [31:0] i_addr, i_data, d_addr, d_data, sdc_q;
  logic        i_we, i_start, d_we, d_start, sdc_done;

  logic [31:0] o_sdc_addr, o_sdc_data, o_i_q, o_d_q;
  logic        o_sdc_we, o_sdc_start, o_i_done, o_d_done;

  int total = 0;
  int bad   = 0;
  int low_run = 0;
  int last_gap = 0;

  txn_t        qi[$];
  txn_t        qd[$];
  logic        mlast;
  logic [31:0] mq[2];

  l1_sdram_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
  l1_sdram_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

  l1_sdram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_ENABLE(1'b1)) u_dut_rr (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  l1_sdram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_ENABLE(1'b0)) u_dut_fix (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  assign bus0.i_addr = i_addr;   assign bus1.i_addr = i_addr;
  assign bus0.i_data = i_data;   assign bus1.i_data = i_data;
  assign bus0.i_we = i_we;       assign bus1.i_we = i_we;
  assign bus0.i_start = i_start; assign bus1.i_start = i_start;
  assign bus0.d_addr = d_addr;   assign bus1.d_addr = d_addr;
  assign bus0.d_data = d_data;   assign bus1.d_data = d_data;
  assign bus0.d_we = d_we;       assign bus1.d_we = d_we;
  assign bus0.d_start = d_start; assign bus1.d_start = d_start;
  assign bus0.sdc_q = sdc_q;     assign bus1.sdc_q = sdc_q;
  assign bus0.sdc_done = sdc_done; assign bus1.sdc_done = sdc_done;

  always_comb begin
    o_sdc_addr  = sel ? bus1.sdc_addr  : bus0.sdc_addr;
    o_sdc_data  = sel ? bus1.sdc_data  : bus0.sdc_data;
    o_sdc_we    = sel ? bus1.sdc_we    : bus0.sdc_we;
    o_sdc_start = sel ? bus1.sdc_start : bus0.sdc_start;
    o_i_q       = sel ? bus1.i_q       : bus0.i_q;
    o_i_done    = sel ? bus1.i_done    : bus0.i_done;
    o_d_q       = sel ? bus1.d_q       : bus0.d_q;
    o_d_done    = sel ? bus1.d_done    : bus0.d_done;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle; also tracks how long sdc_start was low before each rise.
  task automatic tick();
    @(negedge clk);
    if (o_sdc_start) begin
      if (low_run > 0) last_gap = low_run;
      low_run = 0;
    end else begin
      low_run++;
    end
  endtask

  task automatic push(input txn_t t);
    if (t.port) qd.push_back(t);
    else qi.push_back(t);
  endtask

  task automatic req(input logic port, input logic [31:0] a, input logic [31:0] dt,
                     input logic we);
    txn_t t;
    t.port = port; t.addr = a; t.data = dt; t.we = we;
    if (port) begin
      d_addr = a; d_data = dt; d_we = we; d_start = 1'b1;
    end else begin
      i_addr = a; i_data = dt; i_we = we; i_start = 1'b1;
    end
    push(t);
  endtask

  task automatic model_reset();
    mlast = 1'b1;
    mq[0] = 32'h0;
    mq[1] = 32'h0;
    qi.delete();
    qd.delete();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) begin
      tick();
      check("rst_start", {31'd0, o_sdc_start}, 32'd0);
    end
    reset = 1'b1;
    model_reset();
  endtask

  task automatic wait_grant(input bit gap_chk, output bit ok, output txn_t t);
    int  n;
    logic p;
    ok = 1'b0;
    t.port = 1'b0; t.addr = 32'h0; t.data = 32'h0; t.we = 1'b0;
    if (qi.size() == 0 && qd.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
      return;
    end
    if (qi.size() != 0 && qd.size() != 0) p = (sel == 1'b0) ? ~mlast : 1'b1;
    else p = (qd.size() != 0);
    t = p ? qd.pop_front() : qi.pop_front();
    mlast = p;
    n = 0;
    while (!o_sdc_start && n < 30) begin
      tick();
      n++;
    end
    if (!o_sdc_start) begin
      check("grant_timeout", 32'd0, 32'd1);
      return;
    end
    check("grant_addr", o_sdc_addr, t.addr);
    check("grant_data", o_sdc_data, t.data);
    check("grant_we", {31'd0, o_sdc_we}, {31'd0, t.we});
    if (gap_chk) check("start_gap_ge2", {31'd0, last_gap >= 2}, 32'd1);
    ok = 1'b1;
  endtask

  task automatic complete(input txn_t t, input logic [31:0] qv, input int lat,
                          input bit reraise);
    repeat (lat) begin
      tick();
      check("busy_hold", {29'd0, o_sdc_start, o_i_done, o_d_done}, 32'd4);
    end
    sdc_q = qv;
    sdc_done = 1'b1;
    tick();
    sdc_done = 1'b0;
    sdc_q = 32'h0;
    check("done_pulse", {31'd0, t.port ? o_d_done : o_i_done}, 32'd1);
    check("other_done", {31'd0, t.port ? o_i_done : o_d_done}, 32'd0);
    check("q_data", t.port ? o_d_q : o_i_q, qv);
    check("other_q", t.port ? o_i_q : o_d_q, mq[!t.port]);
    check("start_drop", {31'd0, o_sdc_start}, 32'd0);
    mq[t.port] = qv;
    if (t.port) d_start = 1'b0;
    else i_start = 1'b0;
    tick();
    check("done_single", {31'd0, t.port ? o_d_done : o_i_done}, 32'd0);
    if (reraise) begin
      if (t.port) d_start = 1'b1;
      else i_start = 1'b1;
      push(t);
    end
  endtask

  initial begin
    bit   ok;
    txn_t t;
    reset = 1'b0; sel = 1'b0;
    i_addr = 32'h0; i_data = 32'h0; i_we = 1'b0; i_start = 1'b0;
    d_addr = 32'h0; d_data = 32'h0; d_we = 1'b0; d_start = 1'b0;
    sdc_q = 32'h0; sdc_done = 1'b0;
    model_reset();

    // Reset held 3 cycles with both clients requesting
    i_addr = 32'h000123; i_data = 32'h0; i_we = 1'b0; i_start = 1'b1;
    d_addr = 32'h20; d_data = 32'h55AA; d_we = 1'b1; d_start = 1'b1;
    repeat (3) begin
      tick();
      check("rst_start", {31'd0, o_sdc_start}, 32'd0);
    end
    check("rst_sdc_addr", o_sdc_addr, 32'h0);
    check("rst_sdc_data", o_sdc_data, 32'h0);
    check("rst_dones", {30'd0, o_i_done, o_d_done}, 32'd0);
    check("rst_i_q", o_i_q, 32'h0);
    check("rst_d_q", o_d_q, 32'h0);
    reset = 1'b1;
    req(1'b0, 32'h000123, 32'h0, 1'b0);
    req(1'b1, 32'h20, 32'h55AA, 1'b1);

    // I wins the first tie, single read returns DEADBEEF
    wait_grant(1'b0, ok, t);
    if (ok) complete(t, 32'hDEADBEEF, 5, 1'b0);
    wait_grant(1'b1, ok, t);
    if (ok) complete(t, 32'h00001234, 3, 1'b0);

    // Simultaneous requests: I read at 0x10, D write 0x55AA at 0x20
    tick();
    req(1'b0, 32'h10, 32'h0, 1'b0);
    req(1'b1, 32'h20, 32'h55AA, 1'b1);
    for (int k = 0; k < 2; k++) begin
      wait_grant(k > 0, ok, t);
      if (ok) complete(t, 32'hC0DE0000 + k, 4, 1'b0);
    end

    // Fairness under continuous contention
    tick();
    req(1'b0, 32'h100, 32'h0, 1'b0);
    req(1'b1, 32'h200, 32'hA5, 1'b1);
    for (int k = 0; k < 8; k++) begin
      wait_grant(k > 0, ok, t);
      if (ok) complete(t, 32'h1000 + k, 2, k < 6);
    end

    // Fixed priority instance: D wins every tie
    sel = 1'b1;
    do_reset(2);
    req(1'b0, 32'h10, 32'h0, 1'b0);
    req(1'b1, 32'h20, 32'h77, 1'b1);
    for (int k = 0; k < 4; k++) begin
      wait_grant(k > 0, ok, t);
      if (ok) complete(t, 32'h2000 + k, 2, k < 2);
    end

    // Reset while BUSY_D, then a stray controller done
    sel = 1'b0;
    do_reset(2);
    req(1'b1, 32'h40, 32'h0, 1'b0);
    wait_grant(1'b0, ok, t);
    repeat (2) begin
      tick();
      check("busy_before_rst", {31'd0, o_sdc_start}, 32'd1);
    end
    reset = 1'b0;
    tick();
    check("midrst_start", {31'd0, o_sdc_start}, 32'd0);
    check("midrst_d_done", {31'd0, o_d_done}, 32'd0);
    d_start = 1'b0;
    reset = 1'b1;
    model_reset();
    tick();
    sdc_q = 32'hBAD0BAD0;
    sdc_done = 1'b1;
    tick();
    sdc_done = 1'b0;
    check("stray_dones", {30'd0, o_i_done, o_d_done}, 32'd0);
    check("stray_d_q", o_d_q, mq[1]);
    check("stray_i_q", o_i_q, mq[0]);
    check("stray_start", {31'd0, o_sdc_start}, 32'd0);
    tick();
    check("stray_dones_late", {30'd0, o_i_done, o_d_done}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
